cpu_run_ctrl: RTL

//  Synthesizable run controller that produces the control inputs min_sopc expects
//  (rst, rdy, stall_test) from a board-level async active-low reset.

---
 rtl/cpu_run_ctrl_if.sv | 37 +++
 rtl/cpu_run_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Control bundle between the run controller and the core/debug side.
//   halt_req   : permanent stop request
//   pause_req  : timed pause request, qualified by pause_len
//   pause_len  : pause length in cycles (0 = no pause)
//   stall_req  : pipeline stall-test request
//   cpu_rst    : core reset, active-high
//   cpu_rdy    : core ready / clock enable
//   stall_test : core stall-test control
//   running    : controller is in RUN
//   done       : sticky completion flag
//   cycle_cnt  : number of cycles with cpu_rdy=1
// slave  = controller side (consumes requests, drives core controls)
// master = board/debug side (drives requests, observes controls)
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             halt_req;
    logic             pause_req;
    logic [7:0]       pause_len;
    logic             stall_req;
    logic             cpu_rst;
    logic             cpu_rdy;
    logic             stall_test;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output halt_req, pause_req, pause_len, stall_req,
        input  cpu_rst, cpu_rdy, stall_test, running, done, cycle_cnt
    );

    modport slave (
        input  halt_req, pause_req, pause_len, stall_req,
        output cpu_rst, cpu_rdy, stall_test, running, done, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the min_sopc core: holds the core in reset after board
// reset, releases it, runs for a bounded number of ready cycles, supports
// timed pauses through cpu_rdy, and stops on a halt request or budget expiry.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : cpu_run_ctrl_if.slave (requests in, core controls/status out)
// All outputs come straight from flops; no input reaches an output
// combinationally.
module cpu_run_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 8,
    parameter int unsigned RUN_LIMIT       = 50000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic         clk,
    input  logic         rst,
    cpu_run_ctrl_if.slave bus
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RUN_LIMIT - 1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]        pause_cnt_q, pause_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              cpu_rdy_q, cpu_rdy_d;
    logic              stall_test_q, stall_test_d;
    logic              running_q, running_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            pause_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            cpu_rst_q    <= 1'b1;
            cpu_rdy_q    <= 1'b0;
            stall_test_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            pause_cnt_q  <= pause_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_rdy_q    <= cpu_rdy_d;
            stall_test_q <= stall_test_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        pause_cnt_d  = pause_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        cpu_rst_d    = cpu_rst_q;
        cpu_rdy_d    = cpu_rdy_q;
        stall_test_d = stall_test_q;
        running_d    = running_q;
        done_d       = done_q;

        case (state_q)
            HOLD: begin
                hold_cnt_d   = hold_cnt_q + 1'b1;
                cpu_rst_d    = 1'b1;
                cpu_rdy_d    = 1'b0;
                stall_test_d = 1'b0;
                running_d    = 1'b0;
                done_d       = 1'b0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                    cpu_rst_d  = 1'b0;
                    cpu_rdy_d  = 1'b1;
                    running_d  = 1'b1;
                end
            end

            RUN: begin
                // The edge that leaves RUN still counts: cpu_rdy was 1 in
                // the cycle that ends at this edge.
                if (cpu_rdy_q) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                stall_test_d = bus.stall_req;
                if (bus.halt_req || (cycle_cnt_q == CNT_LAST)) begin
                    state_d      = DONE;
                    cpu_rdy_d    = 1'b0;
                    stall_test_d = 1'b0;
                    running_d    = 1'b0;
                    done_d       = 1'b1;
                end else if (bus.pause_req && (bus.pause_len != 8'd0)) begin
                    state_d      = PAUSE;
                    pause_cnt_d  = bus.pause_len;
                    cpu_rdy_d    = 1'b0;
                    stall_test_d = 1'b0;
                    running_d    = 1'b0;
                end
            end

            PAUSE: begin
                pause_cnt_d  = pause_cnt_q - 1'b1;
                stall_test_d = 1'b0;
                if (bus.halt_req) begin
                    state_d   = DONE;
                    cpu_rdy_d = 1'b0;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end else if (pause_cnt_q == 8'd1) begin
                    state_d   = RUN;
                    cpu_rdy_d = 1'b1;
                    running_d = 1'b1;
                end
            end

            DONE: begin
                // Terminal; only rst leaves this state.
            end

            default: begin
                state_d      = HOLD;
                hold_cnt_d   = '0;
                pause_cnt_d  = '0;
                cycle_cnt_d  = '0;
                cpu_rst_d    = 1'b1;
                cpu_rdy_d    = 1'b0;
                stall_test_d = 1'b0;
                running_d    = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.cpu_rdy    = cpu_rdy_q;
    assign bus.stall_test = stall_test_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.cycle_cnt  = cycle_cnt_q;

endmodule
